rename_register_file: RTL and testbench
=======================================

Name: rename_register_file

Overview:
- Architectural register file plus rename table for the out-of-order RV32I core.
- It is the responder to the reorder buffer's register interface, and serves three request types:
  - Launch: records which ROB entry will produce each register.
  - Commit: writes retired values into the register file and releases the rename mapping.
  - Query: answers the two decoder source-operand lookups with a dependency ROB id or a ready value.
- Flushes every rename mapping on a branch-mispredict clear.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers (x0..x31).
- ROB_ID_W, 5, width of a ROB id; id 0 means "no dependency", valid ids are 1..31.

Ports:
- clk_in  input  1  system clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- rdy_in  input  1  global ready; when low, all state holds.
- _clear  input  1  mispredict flush from the ROB.
- _rf_launch_ready  input  1  the instruction issued this cycle writes a destination register.
- _rf_launch_rob_id  input  ROB_ID_W  ROB id allocated to that instruction.
- _rf_launch_register_id  input  5  destination register index.
- _rf_commit_ready  input  1  the retiring instruction writes a register this cycle.
- _rf_commit_rob_id  input  ROB_ID_W  ROB id of the retiring instruction.
- _rf_commit_register_id  input  5  destination register of the retiring instruction.
- _rf_commit_value  input  XLEN  result value to write.
- _ask_rd_1, _ask_rd_2  input  5  source register indices queried by the decoder.
- _dep_rd_1, _dep_rd_2  output  ROB_ID_W  pending producer ROB id, or 0 if the value is ready.
- _dep_value_1, _dep_value_2  output  XLEN  register value; meaningful when the matching _dep_rd is 0.

Behaviour:
- State:
  - regs[0..31] holds XLEN-bit values.
  - dep[0..31] holds ROB_ID_W-bit producer ids.
- Reset (asynchronous, rst_in=1):
  - All regs and dep entries go to 0 immediately.
  - Outputs then read 0/0 for every query.
  - Reset mid-operation discards all mappings; no partial update is kept.
- x0:
  - Commits and launches to register 0 are ignored.
  - regs[0] and dep[0] stay 0 permanently.
  - A query of register 0 returns dep 0, value 0.
- Edge update, when rdy_in=1 and rst_in=0, in this order of precedence:
  1. Commit write: if _rf_commit_ready and register≠0, regs[c] <= _rf_commit_value. This applies even when _clear=1.
  2. Commit release: if _rf_commit_ready and dep[c]==_rf_commit_rob_id, dep[c] <= 0. If dep[c] holds a different, newer id, it is untouched.
  3. Launch: if _rf_launch_ready, _clear=0, and register≠0, dep[l] <= _rf_launch_rob_id. When l==c in the same cycle, launch overrides the release in step 2.
  4. Clear: if _clear=1, every dep[i] <= 0 and any launch that cycle is dropped. The register values are kept.
- rdy_in=0: no state changes; outputs still reflect the current state combinationally.
- Query path (combinational, zero latency), for each port k:
  - Let r = _ask_rd_k.
  - If r==0: output dep 0, value 0.
  - Else if _rf_commit_ready, _rf_commit_register_id==r, and dep[r]==_rf_commit_rob_id: output dep 0, value _rf_commit_value (same-cycle commit bypass).
  - Else: output dep[r] and regs[r].
  - There is no bypass from a same-cycle launch. A decoder querying its own destination sees the pre-launch state, which gives correct ordering for instructions such as "add x5,x5,x1".
- Both query ports are independent and may name the same register.
- ROB id 0 is never written into dep by a launch. The ROB never allocates id 0; if it appears, it is treated as "no dependency".

Decomposition:
- Shared package:
  - XLEN, ROB_ID_W, NREG.
  - ROB_NONE = 0 and REG_ZERO = 0.
  - The RV32 opcode constants the ROB uses to derive has-rd.
- One sub-module, rename_read_port: the combinational query/bypass logic, instantiated twice.

Test Plan:
- Reset then query x3 and x0 → dep 0/0, value 0/0. Assert rst_in mid-run after a launch → dep clears without waiting for a clock edge.
- Launch x5←rob 7; next cycle query x5 → dep 7. Commit rob 7, x5, 0x1234 → the same-cycle query returns dep 0, value 0x1234; the next cycle holds regs[5]=0x1234.
- Launch x5←rob 7, then launch x5←rob 9, then commit rob 7 with 0xAA → regs[5]=0xAA, dep stays 9, and the query returns dep 9.
- Same cycle: commit rob 3 to x8 (dep[8]=3) and launch x8←rob 4 → dep[8]=4 and regs[8] updated. A query that cycle returns dep 0 with the committed value (the launch is not visible).
- Set deps x1←2 and x2←5, then pulse _clear together with a launch x6←6 → all deps read 0, x6 dep 0, and register values unchanged.
- Hold rdy_in=0 while driving commit and launch → no state change. Commit or launch to x0 → x0 still reads 0/0.

Source files
------------

// File: rtl/rename_register_file_pkg.sv
// Shared widths, sentinels and RV32 opcode constants for the rename register file and its ROB client.
package rename_register_file_pkg;
  localparam int XLEN         = 32;
  localparam int NREG         = 32;
  localparam int ROB_ID_W     = 5;
  localparam int REG_W        = $clog2(NREG);
  localparam int NUM_RD_PORTS = 2;

  typedef logic [XLEN-1:0]     xlen_t;
  typedef logic [ROB_ID_W-1:0] rob_id_t;
  typedef logic [REG_W-1:0]    reg_idx_t;

  localparam rob_id_t  ROB_NONE = '0;
  localparam reg_idx_t REG_ZERO = '0;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Retiring write as seen by the read ports for the same-cycle bypass.
  typedef struct packed {
    logic     vld;
    rob_id_t  rob_id;
    reg_idx_t reg_id;
    xlen_t    value;
  } commit_byp_t;

  function automatic logic has_rd(input logic [6:0] opcode);
    return (opcode != OPC_BRANCH) && (opcode != OPC_STORE);
  endfunction
endpackage

// File: rtl/rename_register_file_if.sv
// ROB/decoder <-> rename register file bundle: launch, commit, clear and two source queries.
interface rename_register_file_if;
  import rename_register_file_pkg::*;

  logic     _clear;
  logic     _rf_launch_ready;
  rob_id_t  _rf_launch_rob_id;
  reg_idx_t _rf_launch_register_id;
  logic     _rf_commit_ready;
  rob_id_t  _rf_commit_rob_id;
  reg_idx_t _rf_commit_register_id;
  xlen_t    _rf_commit_value;
  reg_idx_t _ask_rd_1;
  reg_idx_t _ask_rd_2;
  rob_id_t  _dep_rd_1;
  rob_id_t  _dep_rd_2;
  xlen_t    _dep_value_1;
  xlen_t    _dep_value_2;

  modport master (
    output _clear, _rf_launch_ready, _rf_launch_rob_id, _rf_launch_register_id,
           _rf_commit_ready, _rf_commit_rob_id, _rf_commit_register_id, _rf_commit_value,
           _ask_rd_1, _ask_rd_2,
    input  _dep_rd_1, _dep_rd_2, _dep_value_1, _dep_value_2
  );

  modport slave (
    input  _clear, _rf_launch_ready, _rf_launch_rob_id, _rf_launch_register_id,
           _rf_commit_ready, _rf_commit_rob_id, _rf_commit_register_id, _rf_commit_value,
           _ask_rd_1, _ask_rd_2,
    output _dep_rd_1, _dep_rd_2, _dep_value_1, _dep_value_2
  );
endinterface

// File: rtl/rename_register_file_read_port.sv
// One combinational source-operand lookup with same-cycle commit bypass; launches are never bypassed.
module rename_read_port
  import rename_register_file_pkg::*;
(
  input  reg_idx_t                         i_ask,
  input  logic [NREG-1:0][ROB_ID_W-1:0]    i_dep,
  input  logic [NREG-1:0][XLEN-1:0]        i_regs,
  input  commit_byp_t                      i_cmt,
  output rob_id_t                          o_dep,
  output xlen_t                            o_value
);
  rob_id_t w_dep_cur;
  logic    w_byp;

  assign w_dep_cur = i_dep[i_ask];
  // Bypass only when the retiring ROB id is still the live producer of this register.
  assign w_byp = i_cmt.vld && (i_cmt.reg_id == i_ask) && (w_dep_cur == i_cmt.rob_id);

  always_comb begin
    o_dep   = ROB_NONE;
    o_value = '0;
    if (i_ask == REG_ZERO) begin
      o_dep   = ROB_NONE;
      o_value = '0;
    end else if (w_byp) begin
      o_dep   = ROB_NONE;
      o_value = i_cmt.value;
    end else begin
      o_dep   = w_dep_cur;
      o_value = i_regs[i_ask];
    end
  end
endmodule

// File: rtl/rename_register_file.sv
// Architectural register file plus rename table; responder to the ROB register interface.
module rename_register_file
  import rename_register_file_pkg::*;
(
  input logic                   clk_in,
  input logic                   rst_in,
  input logic                   rdy_in,
  rename_register_file_if.slave rf
);
  logic [NREG-1:0][XLEN-1:0]          r_regs;
  logic [NREG-1:0][ROB_ID_W-1:0]      r_dep;
  commit_byp_t                        w_cmt;
  logic                               w_cmt_wen;
  logic                               w_lch_wen;
  logic [NUM_RD_PORTS-1:0][REG_W-1:0]    w_ask;
  logic [NUM_RD_PORTS-1:0][ROB_ID_W-1:0] w_dep_rd;
  logic [NUM_RD_PORTS-1:0][XLEN-1:0]     w_dep_val;

  assign w_cmt.vld    = rf._rf_commit_ready;
  assign w_cmt.rob_id = rf._rf_commit_rob_id;
  assign w_cmt.reg_id = rf._rf_commit_register_id;
  assign w_cmt.value  = rf._rf_commit_value;

  assign w_cmt_wen = rf._rf_commit_ready && (rf._rf_commit_register_id != REG_ZERO);
  // A clear drops the launch; id 0 would mean "no dependency" anyway.
  assign w_lch_wen = rf._rf_launch_ready && !rf._clear &&
                     (rf._rf_launch_register_id != REG_ZERO) &&
                     (rf._rf_launch_rob_id != ROB_NONE);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_regs <= '0;
      r_dep  <= '0;
    end else if (rdy_in) begin
      for (int i = 1; i < NREG; i++) begin
        if (w_cmt_wen && (rf._rf_commit_register_id == reg_idx_t'(i)))
          r_regs[i] <= rf._rf_commit_value;
        // Precedence: clear > launch > commit release.
        if (rf._clear)
          r_dep[i] <= ROB_NONE;
        else if (w_lch_wen && (rf._rf_launch_register_id == reg_idx_t'(i)))
          r_dep[i] <= rf._rf_launch_rob_id;
        else if (rf._rf_commit_ready && (rf._rf_commit_register_id == reg_idx_t'(i)) &&
                 (r_dep[i] == rf._rf_commit_rob_id))
          r_dep[i] <= ROB_NONE;
      end
    end
  end

  assign w_ask[0] = rf._ask_rd_1;
  assign w_ask[1] = rf._ask_rd_2;

  for (genvar g = 0; g < NUM_RD_PORTS; g++) begin : g_rd
    rename_read_port u_rd (
      .i_ask   (w_ask[g]),
      .i_dep   (r_dep),
      .i_regs  (r_regs),
      .i_cmt   (w_cmt),
      .o_dep   (w_dep_rd[g]),
      .o_value (w_dep_val[g])
    );
  end

  assign rf._dep_rd_1    = w_dep_rd[0];
  assign rf._dep_rd_2    = w_dep_rd[1];
  assign rf._dep_value_1 = w_dep_val[0];
  assign rf._dep_value_2 = w_dep_val[1];
endmodule

// File: tb/tb_rename_register_file.sv
// Directed scoreboard bench: stimulus queues expected query results, a negedge monitor pops and compares.
module tb_rename_register_file;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;

  rename_register_file_if rf();

  rename_register_file dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .rf     (rf.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  d1;
    logic [31:0] v1;
    logic [4:0]  d2;
    logic [31:0] v2;
  } exp_t;

  exp_t sb[$];
  logic chk_vld = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(negedge clk) begin
    if (chk_vld) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        vectors++;
        if (rf._dep_rd_1 !== e.d1 || rf._dep_value_1 !== e.v1 ||
            rf._dep_rd_2 !== e.d2 || rf._dep_value_2 !== e.v2) begin
          miscompares++;
          $display("FAIL %s: got p1 dep=%0d val=%h p2 dep=%0d val=%h, want p1 dep=%0d val=%h p2 dep=%0d val=%h",
                   e.name, rf._dep_rd_1, rf._dep_value_1, rf._dep_rd_2, rf._dep_value_2,
                   e.d1, e.v1, e.d2, e.v2);
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
    chk_vld = 1'b0;
    rf._clear = 1'b0;
    rf._rf_launch_ready = 1'b0;
    rf._rf_commit_ready = 1'b0;
  endtask

  task automatic launch(input logic [4:0] r, input logic [4:0] id);
    rf._rf_launch_ready = 1'b1;
    rf._rf_launch_register_id = r;
    rf._rf_launch_rob_id = id;
  endtask

  task automatic commit(input logic [4:0] r, input logic [4:0] id, input logic [31:0] v);
    rf._rf_commit_ready = 1'b1;
    rf._rf_commit_register_id = r;
    rf._rf_commit_rob_id = id;
    rf._rf_commit_value = v;
  endtask

  task automatic ask(input logic [4:0] a1, input logic [4:0] a2);
    rf._ask_rd_1 = a1;
    rf._ask_rd_2 = a2;
  endtask

  task automatic expect_q(input string n, input logic [4:0] d1, input logic [31:0] v1,
                          input logic [4:0] d2, input logic [31:0] v2);
    exp_t e;
    e.name = n; e.d1 = d1; e.v1 = v1; e.d2 = d2; e.v2 = v2;
    sb.push_back(e);
    chk_vld = 1'b1;
  endtask

  initial begin
    rf._clear = 1'b0;
    rf._rf_launch_ready = 1'b0;
    rf._rf_launch_rob_id = '0;
    rf._rf_launch_register_id = '0;
    rf._rf_commit_ready = 1'b0;
    rf._rf_commit_rob_id = '0;
    rf._rf_commit_register_id = '0;
    rf._rf_commit_value = '0;
    ask(5'd3, 5'd0);

    next(); ask(5'd3, 5'd0); expect_q("reset_x3_x0", 5'd0, 32'h0, 5'd0, 32'h0);
    next(); rst = 1'b0;

    // Launch visible only next cycle; async reset wipes it before any edge.
    next(); launch(5'd5, 5'd7); ask(5'd5, 5'd0); expect_q("launch_not_bypassed", 5'd0, 32'h0, 5'd0, 32'h0);
    next(); ask(5'd5, 5'd0); expect_q("launch_x5_dep7", 5'd7, 32'h0, 5'd0, 32'h0);
    next(); rst = 1'b1; ask(5'd5, 5'd5); expect_q("async_reset_clears", 5'd0, 32'h0, 5'd0, 32'h0);
    next(); rst = 1'b0;

    // Commit bypass then architectural write.
    next(); launch(5'd5, 5'd7);
    next(); commit(5'd5, 5'd7, 32'h1234); ask(5'd5, 5'd5);
    expect_q("commit_bypass", 5'd0, 32'h1234, 5'd0, 32'h1234);
    next(); ask(5'd5, 5'd0); expect_q("commit_written", 5'd0, 32'h1234, 5'd0, 32'h0);

    // Older commit must not release a newer mapping.
    next(); launch(5'd5, 5'd7);
    next(); launch(5'd5, 5'd9); ask(5'd5, 5'd0); expect_q("relaunch_pre_state", 5'd7, 32'h1234, 5'd0, 32'h0);
    next(); commit(5'd5, 5'd7, 32'hAA); ask(5'd5, 5'd0); expect_q("stale_commit_no_bypass", 5'd9, 32'h1234, 5'd0, 32'h0);
    next(); ask(5'd5, 5'd0); expect_q("stale_commit_value", 5'd9, 32'hAA, 5'd0, 32'h0);

    // Same-cycle commit and launch on one register.
    next(); launch(5'd8, 5'd3);
    next(); commit(5'd8, 5'd3, 32'h55); launch(5'd8, 5'd4); ask(5'd8, 5'd0);
    expect_q("commit_launch_same_cycle", 5'd0, 32'h55, 5'd0, 32'h0);
    next(); ask(5'd8, 5'd0); expect_q("launch_wins_release", 5'd4, 32'h55, 5'd0, 32'h0);

    // Clear drops all mappings and the concurrent launch, keeps values and commit writes.
    next(); launch(5'd1, 5'd2);
    next(); launch(5'd2, 5'd5); ask(5'd1, 5'd0); expect_q("dep_x1", 5'd2, 32'h0, 5'd0, 32'h0);
    next(); rf._clear = 1'b1; launch(5'd6, 5'd6); commit(5'd7, 5'd1, 32'h99); ask(5'd2, 5'd6);
    expect_q("pre_clear", 5'd5, 32'h0, 5'd0, 32'h0);
    next(); ask(5'd1, 5'd2); expect_q("clear_x1_x2", 5'd0, 32'h0, 5'd0, 32'h0);
    next(); ask(5'd6, 5'd5); expect_q("clear_x6_x5", 5'd0, 32'h0, 5'd0, 32'hAA);
    next(); ask(5'd7, 5'd8); expect_q("clear_commit_kept", 5'd0, 32'h99, 5'd0, 32'h55);

    // rdy low freezes state.
    next(); rdy = 1'b0; launch(5'd10, 5'd11); commit(5'd11, 5'd4, 32'h77); ask(5'd10, 5'd11);
    expect_q("stall_during", 5'd0, 32'h0, 5'd0, 32'h0);
    next(); rdy = 1'b1; ask(5'd10, 5'd11); expect_q("stall_no_update", 5'd0, 32'h0, 5'd0, 32'h0);

    // x0 is hardwired.
    next(); launch(5'd0, 5'd3); commit(5'd0, 5'd0, 32'hFF); ask(5'd0, 5'd0);
    expect_q("x0_during", 5'd0, 32'h0, 5'd0, 32'h0);
    next(); ask(5'd0, 5'd0); expect_q("x0_after", 5'd0, 32'h0, 5'd0, 32'h0);

    next();
    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_leftover: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
